// File: rtl/decimal_string_formatter.sv
// ============================================================================
// Module  : decimal_string_formatter
// Brief   : Binary-to-ASCII decimal (double-dabble) with optional "tag=" prefix,
//           presented right-aligned to a string sender via Ready/Busy handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module decimal_string_formatter #(
    parameter int VALUE_BITS               = 32,
    parameter int DIGITS                   = 10,
    parameter int TX_STRING_COUNT_BIT      = 4,
    parameter int TX_STRING_MAX_LENGTH     = 13,
    parameter int TX_STRING_MAX_BIT_LENGTH = TX_STRING_MAX_LENGTH * 8
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic [VALUE_BITS-1:0]               value_in,
    input  logic [7:0]                          tag_in,
    input  logic                                start,
    output logic                                busy,
    output logic [TX_STRING_COUNT_BIT-1:0]      TXStringLen,
    output logic [TX_STRING_MAX_BIT_LENGTH-1:0] TXString,
    output logic                                TXStringReady,
    input  logic                                TXStringBusy
);

    localparam int C_CNT_W = $clog2(VALUE_BITS + 1);
    localparam int C_BCD_W = DIGITS * 4;
    localparam int C_PAD_W = TX_STRING_MAX_BIT_LENGTH - DIGITS * 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CONVERT   = 3'd1,
        S_PACK      = 3'd2,
        S_SEND      = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;

    state_t                          r_state;
    logic [VALUE_BITS-1:0]           r_shift;
    logic [C_BCD_W-1:0]              r_bcd;
    logic [7:0]                      r_tag;
    logic [C_CNT_W-1:0]              r_count;

    logic [C_BCD_W-1:0]              w_bcd_adj;
    logic [DIGITS*8-1:0]             w_dig_ascii;
    logic [TX_STRING_MAX_BIT_LENGTH-1:0] w_ascii;
    logic [TX_STRING_MAX_BIT_LENGTH-1:0] w_str;
    int                              w_ndig;
    int                              w_len;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_nibble
            assign w_bcd_adj[i*4 +: 4]   = (r_bcd[i*4 +: 4] >= 4'd5) ? r_bcd[i*4 +: 4] + 4'd3
                                                                     : r_bcd[i*4 +: 4];
            assign w_dig_ascii[i*8 +: 8] = {4'h3, r_bcd[i*4 +: 4]};
        end
    endgenerate

    assign w_ascii = {{C_PAD_W{1'b0}}, w_dig_ascii};

    // Leading zeros are suppressed, but at least one digit is always emitted.
    always_comb begin
        w_ndig = 1;
        for (int i = 1; i < DIGITS; i++) begin
            if (r_bcd[i*4 +: 4] != 4'd0) begin
                w_ndig = i + 1;
            end
        end
    end

    always_comb begin
        w_str = '0;
        for (int i = 0; i < TX_STRING_MAX_LENGTH; i++) begin
            if (i < w_ndig) begin
                w_str[i*8 +: 8] = w_ascii[i*8 +: 8];
            end else if ((r_tag != 8'd0) && (i == w_ndig)) begin
                w_str[i*8 +: 8] = 8'h3D;
            end else if ((r_tag != 8'd0) && (i == w_ndig + 1)) begin
                w_str[i*8 +: 8] = r_tag;
            end
        end
        w_len = (r_tag != 8'd0) ? w_ndig + 2 : w_ndig;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_bcd         <= '0;
            r_tag         <= '0;
            r_count       <= '0;
            busy          <= 1'b0;
            TXStringLen   <= '0;
            TXString      <= '0;
            TXStringReady <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift <= value_in;
                        r_tag   <= tag_in;
                        r_bcd   <= '0;
                        r_count <= C_CNT_W'(VALUE_BITS);
                        busy    <= 1'b1;
                        r_state <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    r_bcd   <= {w_bcd_adj[C_BCD_W-2:0], r_shift[VALUE_BITS-1]};
                    r_shift <= {r_shift[VALUE_BITS-2:0], 1'b0};
                    r_count <= r_count - C_CNT_W'(1);
                    if (r_count == C_CNT_W'(1)) begin
                        r_state <= S_PACK;
                    end
                end
                S_PACK: begin
                    TXString    <= w_str;
                    TXStringLen <= TX_STRING_COUNT_BIT'(w_len);
                    r_state     <= S_SEND;
                end
                S_SEND: begin
                    // Ready is always asserted for at least one cycle, even if the sender is already busy.
                    if (!TXStringReady) begin
                        TXStringReady <= 1'b1;
                    end else if (TXStringBusy) begin
                        TXStringReady <= 1'b0;
                        r_state       <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!TXStringBusy) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_decimal_string_formatter.sv
// ============================================================================
// Module  : tb_decimal_string_formatter
// Brief   : Scoreboard bench for decimal_string_formatter with a sender model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decimal_string_formatter;

    localparam int C_LATENCY = 34;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [31:0]  value_in = '0;
    logic [7:0]   tag_in = '0;
    logic         start = 1'b0;
    logic         busy;
    logic [3:0]   TXStringLen;
    logic [103:0] TXString;
    logic         TXStringReady;
    logic         TXStringBusy = 1'b0;
    bit           hold = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]   len;
        logic [103:0] str;
    } exp_t;
    exp_t exp_q[$];

    decimal_string_formatter dut (
        .clk           (clk),
        .resetn        (resetn),
        .value_in      (value_in),
        .tag_in        (tag_in),
        .start         (start),
        .busy          (busy),
        .TXStringLen   (TXStringLen),
        .TXString      (TXString),
        .TXStringReady (TXStringReady),
        .TXStringBusy  (TXStringBusy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sender model: answers Ready with a short busy pulse unless held off.
    initial begin
        forever begin
            @(negedge clk);
            if (TXStringReady && !hold) begin
                TXStringBusy = 1'b1;
                repeat (3) @(negedge clk);
                TXStringBusy = 1'b0;
            end
        end
    end

    // Monitor: every rising Ready is one delivered string.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (TXStringReady && !prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got len %0d str %h expected no output", TXStringLen, TXString);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_len", 128'(TXStringLen), 128'(e.len));
                    check("sb_str", 128'(TXString), 128'(e.str));
                end
            end
            prev = TXStringReady;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [3:0] len, input logic [103:0] str);
        exp_t e;
        e.len = len;
        e.str = str;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [31:0] v, input logic [7:0] t);
        @(negedge clk);
        value_in = v;
        tag_in   = t;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        value_in = 32'hDEAD_BEEF;
        tag_in   = 8'h21;
        check("busy_after_start", 128'(busy), 128'(1));
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!TXStringReady && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("busy_released", 128'(busy), 128'(0));
    endtask

    task automatic run(input logic [31:0] v, input logic [7:0] t,
                       input logic [3:0] len, input logic [103:0] str);
        int c;
        push_exp(len, str);
        issue(v, t);
        wait_ready(c);
        check("ready_latency", 128'(c), 128'(C_LATENCY));
        wait_idle();
    endtask

    initial begin
        int c;
        #12;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_ready", 128'(TXStringReady), 128'(0));
        check("rst_len", 128'(TXStringLen), 128'(0));
        check("rst_str", 128'(TXString), 128'(0));
        @(negedge clk);
        resetn = 1'b1;

        run(32'd0, 8'h00, 4'd1, 104'("0"));
        run(32'd12345, "C", 4'd7, 104'("C=12345"));
        run(32'hFFFF_FFFF, 8'h00, 4'd10, 104'("4294967295"));
        run(32'd100, "X", 4'd5, 104'("X=100"));

        // Second start during conversion is dropped.
        push_exp(4'd2, 104'("55"));
        issue(32'd55, 8'h00);
        repeat (5) @(negedge clk);
        value_in = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_ready(c);
        wait_idle();
        run(32'd7, 8'h00, 4'd1, 104'("7"));

        // Sender stalls for 100 cycles in SEND.
        hold = 1'b1;
        push_exp(4'd7, 104'("H=65535"));
        issue(32'd65535, "H");
        wait_ready(c);
        check("stall_latency", 128'(c), 128'(C_LATENCY));
        repeat (100) @(posedge clk);
        #1;
        check("stall_ready", 128'(TXStringReady), 128'(1));
        check("stall_len", 128'(TXStringLen), 128'(7));
        check("stall_str", 128'(TXString), 128'(104'("H=65535")));
        check("stall_busy", 128'(busy), 128'(1));
        hold = 1'b0;
        wait_idle();

        // Sender already busy when SEND is entered.
        hold = 1'b1;
        TXStringBusy = 1'b1;
        push_exp(4'd1, 104'("9"));
        issue(32'd9, 8'h00);
        wait_ready(c);
        check("prebusy_latency", 128'(c), 128'(C_LATENCY));
        @(posedge clk);
        #1;
        check("prebusy_ready_drop", 128'(TXStringReady), 128'(0));
        check("prebusy_busy", 128'(busy), 128'(1));
        TXStringBusy = 1'b0;
        hold = 1'b0;
        wait_idle();

        // Reset mid-conversion discards everything.
        issue(32'd12345, "C");
        repeat (10) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_ready", 128'(TXStringReady), 128'(0));
        check("abort_str", 128'(TXString), 128'(0));
        check("abort_len", 128'(TXStringLen), 128'(0));
        @(negedge clk);
        resetn = 1'b1;
        run(32'd42, 8'h00, 4'd2, 104'("42"));

        repeat (5) @(negedge clk);
        check("sb_drained", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
